// File: rtl/system_port_arbiter.sv
// system_port_arbiter
// Arbitrates NCH core channels plus one testbench channel onto a single
// memory port. Cores are served round-robin; the testbench channel takes
// exclusive ownership while tbCTRL is high. Every access completes with a
// one-cycle ack pulse to its owner, or with err set if mem_ready does not
// arrive within TIMEOUT cycles. Per-core halts are folded into a sticky
// system halt.
//
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   tbCTRL                        testbench owns the memory port when high
//   tb_wen/tb_ren/tb_addr/tb_store  testbench request channel
//   tb_ack                        testbench done pulse
//   ch_wen/ch_ren/ch_addr/ch_store  packed per-core request channels
//   ch_halt                       per-core halted flags
//   ch_ack                        per-core done pulse (one-hot)
//   load, err                     read data / timeout flag, valid with ack
//   mem_wen/mem_ren/mem_addr/mem_store  memory request (registered)
//   mem_load, mem_ready           memory response
//   halt                          sticky system halt
module system_port_arbiter #(
   parameter int unsigned NCH     = 4,
   parameter int unsigned WORD_W  = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    tbCTRL,
   input  logic                    tb_wen,
   input  logic                    tb_ren,
   input  logic [ADDR_W-1:0]       tb_addr,
   input  logic [WORD_W-1:0]       tb_store,
   output logic                    tb_ack,
   input  logic [NCH-1:0]          ch_wen,
   input  logic [NCH-1:0]          ch_ren,
   input  logic [NCH*ADDR_W-1:0]   ch_addr,
   input  logic [NCH*WORD_W-1:0]   ch_store,
   input  logic [NCH-1:0]          ch_halt,
   output logic [NCH-1:0]          ch_ack,
   output logic [WORD_W-1:0]       load,
   output logic                    err,
   output logic                    mem_wen,
   output logic                    mem_ren,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [WORD_W-1:0]       mem_store,
   input  logic [WORD_W-1:0]       mem_load,
   input  logic                    mem_ready,
   output logic                    halt
);

   localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t              r_state,     w_state_n;
   logic [IDX_W-1:0]    r_rr_ptr,    w_rr_ptr_n;
   logic [CNT_W-1:0]    r_cnt,       w_cnt_n;
   logic [IDX_W-1:0]    r_owner,     w_owner_n;
   logic                r_owner_tb,  w_owner_tb_n;
   logic                r_mem_wen,   w_mem_wen_n;
   logic                r_mem_ren,   w_mem_ren_n;
   logic [ADDR_W-1:0]   r_mem_addr,  w_mem_addr_n;
   logic [WORD_W-1:0]   r_mem_store, w_mem_store_n;
   logic [WORD_W-1:0]   r_load,      w_load_n;
   logic                r_err,       w_err_n;
   logic                r_tb_ack,    w_tb_ack_n;
   logic [NCH-1:0]      r_ch_ack,    w_ch_ack_n;
   logic                r_halt,      w_halt_n;

   logic [NCH-1:0]      w_core_elig;
   logic                w_core_found;
   logic [IDX_W-1:0]    w_core_sel;
   logic                w_core_wr;
   logic [ADDR_W-1:0]   w_core_addr;
   logic [WORD_W-1:0]   w_core_store;
   logic                w_tb_req;
   logic                w_timeout;
   logic                w_ack_fire;

   assign w_tb_req    = tb_wen | tb_ren;
   assign w_core_elig = (ch_wen | ch_ren) & ~ch_halt;
   assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT - 1));

   // Round-robin pick: pass 0 scans cores above the pointer, pass 1 wraps
   // around to the pointer itself, so the last owner ranks lowest.
   always_comb begin
      w_core_found = 1'b0;
      w_core_sel   = '0;
      w_core_wr    = 1'b0;
      w_core_addr  = '0;
      w_core_store = '0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < NCH; i++) begin
            if (!w_core_found && w_core_elig[i] &&
                ((p == 0) ? (IDX_W'(i) > r_rr_ptr) : (IDX_W'(i) <= r_rr_ptr))) begin
               w_core_found = 1'b1;
               w_core_sel   = IDX_W'(i);
               w_core_wr    = ch_wen[i];
               w_core_addr  = ch_addr[i*ADDR_W +: ADDR_W];
               w_core_store = ch_store[i*WORD_W +: WORD_W];
            end
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state_n     = r_state;
      w_rr_ptr_n    = r_rr_ptr;
      w_cnt_n       = r_cnt;
      w_owner_n     = r_owner;
      w_owner_tb_n  = r_owner_tb;
      w_mem_wen_n   = r_mem_wen;
      w_mem_ren_n   = r_mem_ren;
      w_mem_addr_n  = r_mem_addr;
      w_mem_store_n = r_mem_store;
      w_load_n      = r_load;
      w_err_n       = r_err;
      w_tb_ack_n    = 1'b0;
      w_ch_ack_n    = '0;
      w_ack_fire    = 1'b0;
      // halt only latches with no access in flight
      w_halt_n      = r_halt | ((&ch_halt) & (r_state == S_IDLE));

      unique case (r_state)
         S_IDLE: begin
            w_cnt_n = '0;
            if (tbCTRL) begin
               if (w_tb_req) begin
                  w_owner_tb_n  = 1'b1;
                  w_mem_wen_n   = tb_wen;
                  w_mem_ren_n   = ~tb_wen;
                  w_mem_addr_n  = tb_addr;
                  w_mem_store_n = tb_store;
                  w_state_n     = S_BUSY;
               end
            end else if (w_core_found) begin
               w_owner_tb_n  = 1'b0;
               w_owner_n     = w_core_sel;
               w_mem_wen_n   = w_core_wr;
               w_mem_ren_n   = ~w_core_wr;
               w_mem_addr_n  = w_core_addr;
               w_mem_store_n = w_core_store;
               w_state_n     = S_BUSY;
            end
         end
         S_BUSY: begin
            w_cnt_n = r_cnt + CNT_W'(1);
            if (mem_ready) begin
               if (r_mem_ren) begin
                  w_load_n = mem_load;
               end
               w_err_n     = 1'b0;
               w_mem_wen_n = 1'b0;
               w_mem_ren_n = 1'b0;
               w_ack_fire  = 1'b1;
               w_state_n   = S_ACK;
            end else if (w_timeout) begin
               w_load_n    = '0;
               w_err_n     = 1'b1;
               w_mem_wen_n = 1'b0;
               w_mem_ren_n = 1'b0;
               w_ack_fire  = 1'b1;
               w_state_n   = S_ACK;
            end
         end
         S_ACK: begin
            if (!r_owner_tb) begin
               w_rr_ptr_n = r_owner;
            end
            w_cnt_n   = '0;
            w_err_n   = 1'b0;
            w_state_n = S_IDLE;
         end
         default: begin
            w_state_n = S_IDLE;
         end
      endcase

      // ack is registered so it appears during the ACK state
      if (w_ack_fire) begin
         if (r_owner_tb) begin
            w_tb_ack_n = 1'b1;
         end else begin
            for (int i = 0; i < NCH; i++) begin
               if (IDX_W'(i) == r_owner) begin
                  w_ch_ack_n[i] = 1'b1;
               end
            end
         end
      end
   end

   // State and output registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= S_IDLE;
         r_rr_ptr    <= IDX_W'(NCH - 1);
         r_cnt       <= '0;
         r_owner     <= '0;
         r_owner_tb  <= 1'b0;
         r_mem_wen   <= 1'b0;
         r_mem_ren   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_store <= '0;
         r_load      <= '0;
         r_err       <= 1'b0;
         r_tb_ack    <= 1'b0;
         r_ch_ack    <= '0;
         r_halt      <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_rr_ptr    <= w_rr_ptr_n;
         r_cnt       <= w_cnt_n;
         r_owner     <= w_owner_n;
         r_owner_tb  <= w_owner_tb_n;
         r_mem_wen   <= w_mem_wen_n;
         r_mem_ren   <= w_mem_ren_n;
         r_mem_addr  <= w_mem_addr_n;
         r_mem_store <= w_mem_store_n;
         r_load      <= w_load_n;
         r_err       <= w_err_n;
         r_tb_ack    <= w_tb_ack_n;
         r_ch_ack    <= w_ch_ack_n;
         r_halt      <= w_halt_n;
      end
   end

   assign tb_ack    = r_tb_ack;
   assign ch_ack    = r_ch_ack;
   assign load      = r_load;
   assign err       = r_err;
   assign mem_wen   = r_mem_wen;
   assign mem_ren   = r_mem_ren;
   assign mem_addr  = r_mem_addr;
   assign mem_store = r_mem_store;
   assign halt      = r_halt;

endmodule

// File: tb/tb_system_port_arbiter.sv
// tb_system_port_arbiter
// Bench for system_port_arbiter with NCH=4, 32-bit buses, TIMEOUT=8.
// Table-driven single transactions, randomized transactions against a
// transaction-level model, and hand sequences for halt and mid-access reset.
module tb_system_port_arbiter;

   localparam int unsigned NCH     = 4;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned TIMEOUT = 8;

   logic                   CLK;
   logic                   RST;
   logic                   tbCTRL;
   logic                   tb_wen;
   logic                   tb_ren;
   logic [ADDR_W-1:0]      tb_addr;
   logic [WORD_W-1:0]      tb_store;
   logic                   tb_ack;
   logic [NCH-1:0]         ch_wen;
   logic [NCH-1:0]         ch_ren;
   logic [NCH*ADDR_W-1:0]  ch_addr;
   logic [NCH*WORD_W-1:0]  ch_store;
   logic [NCH-1:0]         ch_halt;
   logic [NCH-1:0]         ch_ack;
   logic [WORD_W-1:0]      load;
   logic                   err;
   logic                   mem_wen;
   logic                   mem_ren;
   logic [ADDR_W-1:0]      mem_addr;
   logic [WORD_W-1:0]      mem_store;
   logic [WORD_W-1:0]      mem_load;
   logic                   mem_ready;
   logic                   halt;

   system_port_arbiter #(
      .NCH(NCH), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK(CLK), .RST(RST), .tbCTRL(tbCTRL),
      .tb_wen(tb_wen), .tb_ren(tb_ren), .tb_addr(tb_addr), .tb_store(tb_store),
      .tb_ack(tb_ack),
      .ch_wen(ch_wen), .ch_ren(ch_ren), .ch_addr(ch_addr), .ch_store(ch_store),
      .ch_halt(ch_halt), .ch_ack(ch_ack),
      .load(load), .err(err),
      .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
      .mem_store(mem_store), .mem_load(mem_load), .mem_ready(mem_ready),
      .halt(halt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        tbctrl;
      logic        tb_w;
      logic        tb_r;
      logic [3:0]  cw;
      logic [3:0]  cr;
      logic [3:0]  hl;
      int          dly;
      logic [31:0] rdata;
      logic        exp_grant;
      logic        exp_tb;
      logic [3:0]  exp_ch;
      logic        exp_wr;
      logic [31:0] exp_addr;
      logic [31:0] exp_store;
      logic        exp_err;
      logic [31:0] exp_load;
      int          exp_strobes;
   } vec_t;

   int          n_checks;
   int          n_fail;
   string       ctx;
   logic [31:0] c_addr [4];
   logic [31:0] c_store [4];
   logic [31:0] t_addr;
   logic [31:0] t_store;
   vec_t        tbl [14];

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s/%s actual=%0h required=%0h", ctx, nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic tbc, input logic tw, input logic tr,
                               input logic [3:0] cw, input logic [3:0] cr,
                               input logic [3:0] hl, input int dly,
                               input logic [31:0] rd, input logic etb,
                               input logic [3:0] ech, input logic ewr,
                               input logic [31:0] eaddr, input logic [31:0] estore,
                               input logic eerr, input logic [31:0] eload,
                               input int estr);
      vec_t v;
      v.tbctrl = tbc;  v.tb_w = tw;  v.tb_r = tr;
      v.cw = cw;  v.cr = cr;  v.hl = hl;
      v.dly = dly;  v.rdata = rd;
      v.exp_tb = etb;  v.exp_ch = ech;
      v.exp_grant = etb | (|ech);
      v.exp_wr = ewr;  v.exp_addr = eaddr;  v.exp_store = estore;
      v.exp_err = eerr;  v.exp_load = eload;  v.exp_strobes = estr;
      return v;
   endfunction

   task automatic drive_bus();
      tb_addr  = t_addr;
      tb_store = t_store;
      for (int i = 0; i < 4; i++) begin
         ch_addr[i*32 +: 32]  = c_addr[i];
         ch_store[i*32 +: 32] = c_store[i];
      end
   endtask

   task automatic clear_req();
      tb_wen = 1'b0;
      tb_ren = 1'b0;
      ch_wen = '0;
      ch_ren = '0;
   endtask

   task automatic check_all_zero();
      check("rst_tb_ack",    64'(tb_ack),    64'(0));
      check("rst_ch_ack",    64'(ch_ack),    64'(0));
      check("rst_load",      64'(load),      64'(0));
      check("rst_err",       64'(err),       64'(0));
      check("rst_mem_wen",   64'(mem_wen),   64'(0));
      check("rst_mem_ren",   64'(mem_ren),   64'(0));
      check("rst_mem_addr",  64'(mem_addr),  64'(0));
      check("rst_mem_store", 64'(mem_store), 64'(0));
      check("rst_halt",      64'(halt),      64'(0));
   endtask

   // One request set applied from IDLE, memory answers after v.dly BUSY cycles.
   task automatic do_txn(input vec_t v, input bit rnd);
      int   k;
      int   strobes;
      logic got;
      tbCTRL  = v.tbctrl;
      tb_wen  = v.tb_w;
      tb_ren  = v.tb_r;
      ch_wen  = v.cw;
      ch_ren  = v.cr;
      ch_halt = v.hl;
      drive_bus();
      mem_ready = 1'b0;
      step();
      if (!v.exp_grant) begin
         check("nogrant_strobe", 64'({mem_wen, mem_ren}), 64'(0));
         step();
         check("nogrant_ack", 64'({tb_ack, ch_ack}), 64'(0));
         check("nogrant_load", 64'(load), 64'(v.exp_load));
         clear_req();
         step();
         return;
      end
      check("grant_wen",  64'(mem_wen),  64'(v.exp_wr));
      check("grant_ren",  64'(mem_ren),  64'(!v.exp_wr));
      check("grant_addr", 64'(mem_addr), 64'(v.exp_addr));
      if (v.exp_wr) check("grant_store", 64'(mem_store), 64'(v.exp_store));
      k = 0;
      strobes = 0;
      got = 1'b0;
      while (!got && k < 30) begin
         if (mem_wen | mem_ren) strobes++;
         mem_ready = (k == v.dly);
         mem_load  = v.rdata;
         if (rnd) tbCTRL = 1'($urandom);
         step();
         k++;
         if (tb_ack | (|ch_ack)) got = 1'b1;
      end
      mem_ready = 1'b0;
      check("ack_seen",    64'(got),     64'(1));
      check("strobe_cnt",  64'(strobes), 64'(v.exp_strobes));
      check("tb_ack",      64'(tb_ack),  64'(v.exp_tb));
      check("ch_ack",      64'(ch_ack),  64'(v.exp_ch));
      check("err",         64'(err),     64'(v.exp_err));
      check("load",        64'(load),    64'(v.exp_load));
      check("ack_strobe",  64'({mem_wen, mem_ren}), 64'(0));
      clear_req();
      step();
      check("ack_pulse",   64'({tb_ack, ch_ack}), 64'(0));
      check("halt_low",    64'(halt),    64'(0));
   endtask

   task automatic do_reset();
      RST = 1'b1;
      clear_req();
      mem_ready = 1'b0;
      step();
      step();
      RST = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        v;
      int          m_ptr;
      logic [31:0] m_load;
      logic [3:0]  elig;
      int          own;
      int          c;
      logic        found;
      logic        got;
      int          k;

      n_checks = 0;
      n_fail   = 0;
      ctx      = "reset";
      RST = 1'b1;  tbCTRL = 1'b0;  ch_halt = '0;
      mem_load = '0;  mem_ready = 1'b0;
      tb_addr = '0;  tb_store = '0;  ch_addr = '0;  ch_store = '0;
      clear_req();
      for (int i = 0; i < 4; i++) begin
         c_addr[i]  = 32'h100 + 32'(4 * i);
         c_store[i] = 32'hA000_0000 + 32'(i);
      end
      t_addr  = 32'h40;
      t_store = 32'h1234;

      tbl[0]  = mk(0,0,0, 4'h0,4'h1,4'h0, 0,32'hDEADBEEF, 0,4'h1,0, 32'h100,32'hA0000000, 0,32'hDEADBEEF, 1);
      tbl[1]  = mk(0,0,0, 4'hF,4'h0,4'h0, 0,32'h11111111, 0,4'h2,1, 32'h104,32'hA0000001, 0,32'hDEADBEEF, 1);
      tbl[2]  = mk(0,0,0, 4'hF,4'h0,4'h0, 0,32'h11111111, 0,4'h4,1, 32'h108,32'hA0000002, 0,32'hDEADBEEF, 1);
      tbl[3]  = mk(0,0,0, 4'hF,4'h0,4'h0, 0,32'h11111111, 0,4'h8,1, 32'h10C,32'hA0000003, 0,32'hDEADBEEF, 1);
      tbl[4]  = mk(0,0,0, 4'hF,4'h0,4'h0, 0,32'h11111111, 0,4'h1,1, 32'h100,32'hA0000000, 0,32'hDEADBEEF, 1);
      tbl[5]  = mk(0,0,0, 4'hF,4'h0,4'h0, 0,32'h11111111, 0,4'h2,1, 32'h104,32'hA0000001, 0,32'hDEADBEEF, 1);
      tbl[6]  = mk(1,1,1, 4'h0,4'h4,4'h0, 1,32'hFFFFFFFF, 1,4'h0,1, 32'h40,32'h1234,      0,32'hDEADBEEF, 2);
      tbl[7]  = mk(0,1,0, 4'h0,4'h4,4'h0, 0,32'h55AA55AA, 0,4'h4,0, 32'h108,32'hA0000002, 0,32'h55AA55AA, 1);
      tbl[8]  = mk(0,0,0, 4'h0,4'h2,4'h0, 9,32'h77777777, 0,4'h2,0, 32'h104,32'hA0000001, 1,32'h0,        8);
      tbl[9]  = mk(0,0,0, 4'h0,4'h2,4'h0, 2,32'h0BADF00D, 0,4'h2,0, 32'h104,32'hA0000001, 0,32'h0BADF00D, 3);
      tbl[10] = mk(0,0,0, 4'h0,4'hF,4'hB, 5,32'h12345678, 0,4'h4,0, 32'h108,32'hA0000002, 0,32'h12345678, 6);
      tbl[11] = mk(0,0,0, 4'h8,4'h8,4'h0, 0,32'h0,        0,4'h8,1, 32'h10C,32'hA0000003, 0,32'h12345678, 1);
      tbl[12] = mk(0,1,0, 4'h0,4'h0,4'h0, 0,32'h0,        0,4'h0,0, 32'h0,32'h0,          0,32'h12345678, 0);
      tbl[13] = mk(1,0,0, 4'h0,4'h1,4'h0, 0,32'h0,        0,4'h0,0, 32'h0,32'h0,          0,32'h12345678, 0);

      step();
      step();
      check_all_zero();
      RST = 1'b0;

      // table-driven single transactions
      for (int r = 0; r < 14; r++) begin
         ctx = $sformatf("tbl%0d", r);
         do_txn(tbl[r], 1'b0);
      end

      // randomized transactions against a transaction-level model
      ctx = "rnd_reset";
      do_reset();
      m_ptr  = 3;
      m_load = '0;
      for (int n = 0; n < 200; n++) begin
         ctx = $sformatf("rnd%0d", n);
         v.tbctrl = ($urandom_range(0, 3) == 0);
         v.tb_w   = 1'($urandom);
         v.tb_r   = 1'($urandom);
         v.cw     = 4'($urandom);
         v.cr     = 4'($urandom);
         v.hl     = 4'($urandom);
         if (v.hl == 4'hF) v.hl = 4'h7;
         v.dly    = $urandom_range(0, 9);
         v.rdata  = $urandom;
         for (int i = 0; i < 4; i++) begin
            c_addr[i]  = $urandom;
            c_store[i] = $urandom;
         end
         t_addr  = $urandom;
         t_store = $urandom;

         v.exp_tb = 1'b0;
         v.exp_ch = '0;
         v.exp_wr = 1'b0;
         v.exp_addr = '0;
         v.exp_store = '0;
         own = -1;
         if (v.tbctrl) begin
            v.exp_grant = v.tb_w | v.tb_r;
            if (v.exp_grant) begin
               v.exp_tb    = 1'b1;
               v.exp_wr    = v.tb_w;
               v.exp_addr  = t_addr;
               v.exp_store = t_store;
            end
         end else begin
            elig  = (v.cw | v.cr) & ~v.hl;
            found = 1'b0;
            for (int s = 1; s <= 4; s++) begin
               c = (m_ptr + s) % 4;
               if (!found && (((elig >> c) & 4'd1) != 4'd0)) begin
                  found = 1'b1;
                  own   = c;
               end
            end
            v.exp_grant = found;
            if (found) begin
               v.exp_ch    = 4'd1 << own;
               v.exp_wr    = ((v.cw >> own) & 4'd1) != 4'd0;
               v.exp_addr  = c_addr[own];
               v.exp_store = c_store[own];
            end
         end
         v.exp_err     = v.exp_grant && (v.dly >= int'(TIMEOUT));
         v.exp_strobes = v.exp_err ? int'(TIMEOUT) : v.dly + 1;
         if (v.exp_grant) begin
            if (v.exp_err) m_load = '0;
            else if (!v.exp_wr) m_load = v.rdata;
            if (own >= 0) m_ptr = own;
         end
         v.exp_load = m_load;
         do_txn(v, 1'b1);
      end

      // halt: partial halt with core 2 in flight, then all halted mid-access
      ctx = "halt";
      do_reset();
      for (int i = 0; i < 4; i++) begin
         c_addr[i]  = 32'h200 + 32'(4 * i);
         c_store[i] = 32'h0;
      end
      drive_bus();
      tbCTRL  = 1'b0;
      ch_halt = 4'b1011;
      ch_ren  = 4'b0100;
      step();
      check("halt_grant_addr", 64'(mem_addr), 64'(32'h208));
      k   = 0;
      got = 1'b0;
      while (!got && k < 30) begin
         check("halt_busy_low", 64'(halt), 64'(0));
         if (k == 1) ch_halt = 4'b1111;
         mem_ready = (k == 5);
         mem_load  = 32'hCAFE0002;
         step();
         k++;
         if (|ch_ack) got = 1'b1;
      end
      mem_ready = 1'b0;
      check("halt_ack", 64'(ch_ack), 64'(4'b0100));
      check("halt_ack_low", 64'(halt), 64'(0));
      clear_req();
      step();
      step();
      check("halt_set", 64'(halt), 64'(1));
      ch_ren = 4'b1111;
      ch_wen = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         step();
         check("halted_no_grant", 64'({mem_wen, mem_ren, ch_ack}), 64'(0));
      end
      clear_req();
      ch_halt = 4'b0000;
      step();
      check("halt_sticky", 64'(halt), 64'(1));

      // reset during BUSY: no ack, all outputs cleared, ch0 wins first after
      ctx = "rst_busy";
      do_reset();
      check("rst_clears_halt", 64'(halt), 64'(0));
      ch_ren = 4'b1000;
      step();
      check("rb_grant_ch3", 64'(mem_addr), 64'(32'h20C));
      step();
      step();
      ch_ren = 4'b1111;
      RST = 1'b1;
      step();
      check_all_zero();
      RST = 1'b0;
      step();
      check("rb_restart_ren",  64'(mem_ren),  64'(1));
      check("rb_restart_addr", 64'(mem_addr), 64'(32'h200));
      check("rb_no_ack",       64'({tb_ack, ch_ack}), 64'(0));
      mem_ready = 1'b1;
      mem_load  = 32'h0000_5A5A;
      step();
      mem_ready = 1'b0;
      check("rb_ack_ch0", 64'(ch_ack), 64'(4'b0001));
      check("rb_load",    64'(load),   64'(32'h0000_5A5A));
      clear_req();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
